cmos_dvp_tx: RTL and testbench
==============================

# cmos_dvp_tx

DVP camera-port transmitter: serialises a 16-bit RGB565 pixel stream onto an OV5640-style 8-bit parallel interface (vsync/href/data), high byte first. It is the counterpart of the camera capture path and stands in for the OV5640 in simulation and board loopback. Its outputs connect directly to the capture block's cam_vsync/cam_href/cam_data inputs, with cam_pclk tied to this block's clk.

## Interface
- H_PIXEL, 512: pixels per line (≥1)
- V_PIXEL, 768: lines per frame (≥1)
- VS_CYCLES, 1024: clk cycles cam_vsync is high per frame (≥1)
- V_BACK, 512: cycles from vsync fall to first href of the frame (≥1)
- H_BLANK, 64: href-low cycles after every line, including the last (≥1)
- V_FRONT, 512: cycles after the last line's H_BLANK before the next vsync (≥1)

Ports:
- clk  in  1  sole clock; the receiver samples on its rising edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  level; frames are generated while high
- pix_valid  in  1  pixel available
- pix_data  in  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
- pix_ready  out  1  pixel consumed this cycle when pix_valid is high
- cam_vsync  out  1  frame sync, active high
- cam_href  out  1  line valid, active high
- cam_data  out  8  byte bus
- frame_start  out  1  one-cycle pulse, coincident with the first cam_vsync high cycle
- frame_done  out  1  one-cycle pulse on the last V_FRONT cycle
- underflow  out  1  one-cycle pulse when a pixel was due and pix_valid was low

## Operation
- FSM states: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT.
- IDLE: if enable is high, go to VSYNC.
- VSYNC: stay VS_CYCLES cycles, then go to VBACK.
- VBACK: stay V_BACK cycles, then go to LINE.
- LINE: stay 2·H_PIXEL cycles, then go to HBLANK.
- HBLANK: stay H_BLANK cycles. If line_cnt < V_PIXEL−1, increment line_cnt and go to LINE; otherwise go to VFRONT.
- VFRONT: stay V_FRONT cycles, then go to VSYNC if enable is high, else IDLE.
- enable is sampled only in IDLE and at the end of VFRONT. Deasserting it mid-frame completes the frame; no truncated frames are ever emitted.
- Byte phase toggles every LINE cycle, starting at 0.
  - Phase 0: pix_ready=1 (combinational on state/phase only, not on pix_valid).
  - If pix_valid, cam_data takes pix_data[15:8] and a holding register takes pix_data[7:0].
  - If not pix_valid, cam_data takes 8'h00, the holding register takes 8'h00, and underflow pulses. The frame continues with unchanged timing.
  - Phase 1: cam_data takes the holding register.
- cam_data is 8'h00 whenever cam_href is low.
- Counters:
  - cyc_cnt: width $clog2 of the largest state duration; reloads to 0 on every state change.
  - line_cnt: $clog2(V_PIXEL) bits; cleared in VSYNC.
  - No wrap-around beyond the stated maxima.
- Frame length = VS_CYCLES + V_BACK + V_PIXEL·(2·H_PIXEL+H_BLANK) + V_FRONT cycles.

## Timing
- All outputs except pix_ready are registered. cam_vsync, cam_href and cam_data are valid one cycle after the corresponding state cycle (fixed latency 1), mutually aligned.
- Reset (rst_n low at a rising edge):
  - state=IDLE, counters=0.
  - cam_vsync=0, cam_href=0, cam_data=0, frame_start=0, frame_done=0, underflow=0, pix_ready=0.
  - Takes effect from the next cycle, including mid-line. Any partial line or frame is abandoned.
- First frame_start comes 2 cycles after enable is first sampled high in IDLE: 1 cycle IDLE→VSYNC, plus 1 cycle output register.
- Back-to-back frames: the VSYNC rise follows the last VFRONT cycle with no idle gap.
- The first pixel byte is on the bus in the same cycle cam_href rises. cam_href stays high for exactly 2·H_PIXEL consecutive cycles per line.

## Structure
- Shared package cmos_dvp_pkg:
  - state enum (IDLE…VFRONT)
  - RGB565 field widths
  - a width helper function for counter sizing, also used by the capture-side testbench
- Single flat module: FSM, two counters, byte-phase flop, low-byte holding register. No sub-module is warranted.

## Test plan
Parameters for all cases: H_PIXEL=4, V_PIXEL=3, VS_CYCLES=5, V_BACK=3, H_BLANK=2, V_FRONT=4 (frame = 42 cycles).
- Nominal frame: enable=1, pix_valid=1, pixels 16'hA1B2, 16'hA1B3, … → cam_vsync high 5 cycles; first href 3 cycles after vsync falls; line 0 bytes A1,B2,A1,B3,…; 3 href pulses of 8 cycles each; frame_done once; 12 pix_ready pulses; next frame_start exactly 42 cycles after the first.
- Underflow: drop pix_valid on pixel 5 → that pixel's bytes are 00,00, one underflow pulse, all timing identical to nominal.
- Enable drop: deassert enable during line 1 → frame completes with all 3 lines, frame_done pulses, then IDLE with no further vsync.
- Reset mid-line: rst_n low during phase 1 of pixel 2 → next cycle all outputs 0; after release with enable=1, a full fresh frame starts (frame_start 2 cycles later).
- Loopback with the capture block: 3 consecutive frames with incrementing pixel values → every received 16-bit word equals the sent pixel, 12 valid words per frame.
- Backpressure-free source: pix_valid held low for an entire frame → 12 underflow pulses, 24 zero bytes under href, timing unchanged.

Source files
------------

// File: rtl/cmos_dvp_pkg.sv
// cmos_dvp_pkg
//   Shared definitions for the DVP camera-port transmitter and the capture-side
//   testbenches: the frame-timing state enum, RGB565 field widths and a helper
//   that sizes counters from the largest count they must hold.
package cmos_dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_LINE,
    ST_HBLANK,
    ST_VFRONT
  } dvp_state_e;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;
  localparam int BYTE_W  = 8;

  // Bits needed to count 0 .. numStates-1; never less than one bit so a
  // duration of 1 still yields a legal vector.
  function automatic int cnt_width(input int numStates);
    return (numStates > 1) ? $clog2(numStates) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmos_dvp_tx.sv
// cmos_dvp_tx
//   DVP camera-port transmitter. Serialises a 16-bit RGB565 pixel stream onto an
//   OV5640-style 8-bit parallel bus (vsync/href/data), high byte first. Every
//   bus output is registered, so it lags the internal timing state by one
//   cycle; pix_ready is the only combinational output.
//
//   Ports
//     clk          sole clock, receiver samples on the rising edge
//     rst_n        synchronous active-low reset
//     enable       frames are generated while high (checked only between frames)
//     pix_valid    a pixel is offered on pix_data
//     pix_data     RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//     pix_ready    pixel is consumed this cycle if pix_valid is high
//     cam_vsync    frame sync, active high
//     cam_href     line valid, active high
//     cam_data     byte bus, zero whenever cam_href is low
//     frame_start  one-cycle pulse with the first cam_vsync high cycle
//     frame_done   one-cycle pulse on the last front-porch cycle
//     underflow    one-cycle pulse when a pixel was due but pix_valid was low
module cmos_dvp_tx
  import cmos_dvp_pkg::*;
#(
  parameter int H_PIXEL   = 512,
  parameter int V_PIXEL   = 768,
  parameter int VS_CYCLES = 1024,
  parameter int V_BACK    = 512,
  parameter int H_BLANK   = 64,
  parameter int V_FRONT   = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              cam_vsync,
  output logic              cam_href,
  output logic [BYTE_W-1:0] cam_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              underflow
);

  localparam int LINE_CYCLES = 2 * H_PIXEL;
  localparam int MAX_DUR     = max2(max2(max2(VS_CYCLES, V_BACK), max2(LINE_CYCLES, H_BLANK)), V_FRONT);
  localparam int CNT_W       = cnt_width(MAX_DUR);
  localparam int LCNT_W      = cnt_width(V_PIXEL);

  localparam logic [CNT_W-1:0]  VS_LAST    = CNT_W'(VS_CYCLES - 1);
  localparam logic [CNT_W-1:0]  VB_LAST    = CNT_W'(V_BACK - 1);
  localparam logic [CNT_W-1:0]  LN_LAST    = CNT_W'(LINE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HB_LAST    = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]  VF_LAST    = CNT_W'(V_FRONT - 1);
  localparam logic [LCNT_W-1:0] LINES_LAST = LCNT_W'(V_PIXEL - 1);

  dvp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [LCNT_W-1:0] line_q, line_d;
  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] hold_q, hold_d;

  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              fstart_q, fstart_d;
  logic              fdone_q, fdone_d;
  logic              uflow_q, uflow_d;

  // A pixel is taken on the high-byte phase of every line cycle pair; this
  // deliberately ignores pix_valid so the source sees a fixed cadence.
  assign pix_ready = (state_q == ST_LINE) && !phase_q;

  // Frame timing: each state lasts a fixed number of cycles counted by cyc_q,
  // which restarts from zero on every state change. enable is only looked at
  // in IDLE and at the very end of the front porch, so frames are never cut.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    phase_d = 1'b0;
    hold_d  = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        line_d = '0;
        if (cyc_q == VS_LAST) state_d = ST_VBACK;
      end
      ST_VBACK: begin
        if (cyc_q == VB_LAST) state_d = ST_LINE;
      end
      ST_LINE: begin
        phase_d = !phase_q;
        if (!phase_q) hold_d = pix_valid ? pix_data[BYTE_W-1:0] : '0;
        if (cyc_q == LN_LAST) state_d = ST_HBLANK;
      end
      ST_HBLANK: begin
        if (cyc_q == HB_LAST) begin
          if (line_q < LINES_LAST) begin
            line_d  = line_q + LCNT_W'(1);
            state_d = ST_LINE;
          end else begin
            state_d = ST_VFRONT;
          end
        end
      end
      ST_VFRONT: begin
        if (cyc_q == VF_LAST) state_d = enable ? ST_VSYNC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE || state_d != state_q) begin
      cyc_d = '0;
    end else begin
      cyc_d = cyc_q + CNT_W'(1);
    end
  end

  // Bus outputs are a one-cycle-delayed image of the current timing state,
  // which keeps vsync, href and data mutually aligned at the pins.
  always_comb begin
    vsync_d  = (state_q == ST_VSYNC);
    href_d   = (state_q == ST_LINE);
    fstart_d = (state_q == ST_VSYNC) && (cyc_q == '0);
    fdone_d  = (state_q == ST_VFRONT) && (cyc_q == VF_LAST);
    uflow_d  = (state_q == ST_LINE) && !phase_q && !pix_valid;
    data_d   = '0;
    if (state_q == ST_LINE) begin
      if (phase_q) begin
        data_d = hold_q;
      end else if (pix_valid) begin
        data_d = pix_data[PIX_W-1:BYTE_W];
      end
    end
  end

  // Reset abandons any partial line or frame and forces every output low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      line_q   <= '0;
      phase_q  <= 1'b0;
      hold_q   <= '0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      data_q   <= '0;
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      line_q   <= line_d;
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      vsync_q  <= vsync_d;
      href_q   <= href_d;
      data_q   <= data_d;
      fstart_q <= fstart_d;
      fdone_q  <= fdone_d;
      uflow_q  <= uflow_d;
    end
  end

  assign cam_vsync   = vsync_q;
  assign cam_href    = href_q;
  assign cam_data    = data_q;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign underflow   = uflow_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// tb_cmos_dvp_tx
//   Self-checking bench for cmos_dvp_tx with a small frame geometry. Expected
//   bus values come from a frame-position model: the position of a sample
//   inside the frame is turned into vsync/href/byte/pixel index with plain
//   arithmetic, and pixel bytes are looked up in a record of what was offered.
module tb_cmos_dvp_tx;

  localparam int H        = 4;
  localparam int V        = 3;
  localparam int VS       = 5;
  localparam int VB       = 3;
  localparam int HB       = 2;
  localparam int VF       = 4;
  localparam int LINE_LEN = 2 * H + HB;
  localparam int L0       = VS + VB;
  localparam int ACT      = V * LINE_LEN;
  localparam int FRAME    = L0 + ACT + VF;
  localparam int NPIX     = H * V;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_start;
  logic        frame_done;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sentData [NPIX];
  bit          sentValid[NPIX];
  logic [15:0] pixCounter;

  always #5 clk = ~clk;

  cmos_dvp_tx #(
    .H_PIXEL  (H),
    .V_PIXEL  (V),
    .VS_CYCLES(VS),
    .V_BACK   (VB),
    .H_BLANK  (HB),
    .V_FRONT  (VF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  // Frame-position model: s counts cycles from the first vsync cycle.
  function automatic bit isHref(input int s);
    return (s >= L0) && (s < L0 + ACT) && (((s - L0) % LINE_LEN) < 2 * H);
  endfunction

  function automatic int pixIdx(input int s);
    return ((s - L0) / LINE_LEN) * H + (((s - L0) % LINE_LEN) / 2);
  endfunction

  function automatic bit isHi(input int s);
    return (((s - L0) % LINE_LEN) % 2) == 0;
  endfunction

  function automatic bit isReady(input int s);
    return (s < FRAME) && isHref(s) && isHi(s);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rstN, input bit en, input bit pv, input logic [15:0] pd);
    rst_n     = rstN;
    enable    = en;
    pix_valid = pv;
    pix_data  = pd;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vsync"}, cam_vsync, 0);
    checkOutput({tag, "_href"}, cam_href, 0);
    checkOutput({tag, "_data"}, cam_data, 0);
    checkOutput({tag, "_fstart"}, frame_start, 0);
    checkOutput({tag, "_fdone"}, frame_done, 0);
    checkOutput({tag, "_uflow"}, underflow, 0);
    checkOutput({tag, "_ready"}, pix_ready, 0);
  endtask

  // Called at a sample where the DUT sits in IDLE; raises enable and checks
  // the one cycle of IDLE-looking outputs before the frame appears.
  task automatic startFrame();
    enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("start_vsync", cam_vsync, 0);
    checkOutput("start_fstart", frame_start, 0);
  endtask

  // Walks one frame sample by sample. mode: 0 all valid, 1 pixel 5 missing,
  // 2 none valid, 3 random. enable falls to endEnable from sample dropAt on.
  // resetAt >= 0 pulls rst_n at that sample and abandons the frame.
  task automatic runFrame(input int mode, input int dropAt, input bit endEnable, input int resetAt);
    int readyCnt, ufCnt, hrefCnt, fdCnt, invalidCnt, j;
    bit eHref, eHi, eUf, v, aborted;
    logic [7:0] eData;
    readyCnt = 0; ufCnt = 0; hrefCnt = 0; fdCnt = 0; invalidCnt = 0; aborted = 0;
    for (int t = 0; t < FRAME; t++) begin
      @(posedge clk);
      #1;
      eHref = isHref(t);
      eData = 8'h00;
      eUf   = 1'b0;
      if (eHref) begin
        j   = pixIdx(t);
        eHi = isHi(t);
        if (sentValid[j]) eData = eHi ? sentData[j][15:8] : sentData[j][7:0];
        eUf = eHi && !sentValid[j];
      end
      checkOutput("vsync", cam_vsync, (t < VS) ? 1 : 0);
      checkOutput("href", cam_href, eHref);
      checkOutput("data", cam_data, eData);
      checkOutput("frame_start", frame_start, (t == 0) ? 1 : 0);
      checkOutput("frame_done", frame_done, (t == FRAME - 1) ? 1 : 0);
      checkOutput("underflow", underflow, eUf);
      checkOutput("pix_ready", pix_ready, isReady(t + 1));
      readyCnt += pix_ready;
      ufCnt    += underflow;
      hrefCnt  += cam_href;
      fdCnt    += frame_done;

      if (isReady(t + 1)) begin
        j = pixIdx(t + 1);
        case (mode)
          0:       v = 1'b1;
          1:       v = (j != 5);
          2:       v = 1'b0;
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        sentValid[j] = v;
        sentData[j]  = pixCounter;
        pix_valid    = v;
        pix_data     = pixCounter;
        pixCounter   = pixCounter + 16'd1;
        if (!v) invalidCnt++;
      end else begin
        pix_valid = 1'($urandom);
        pix_data  = 16'($urandom);
      end
      enable = (t >= dropAt) ? endEnable : 1'b1;

      if (t == resetAt) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("reset_mid_line");
        rst_n   = 1'b1;
        enable  = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      checkOutput("ready_count", readyCnt, NPIX);
      checkOutput("href_count", hrefCnt, 2 * NPIX);
      checkOutput("done_count", fdCnt, 1);
      checkOutput("underflow_count", ufCnt, invalidCnt);
    end
  endtask

  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkAllZero("idle");
      pix_valid = 1'($urandom);
    end
  endtask

  typedef struct {
    bit rstN;
    bit en;
    bit expVsync;
    bit expFstart;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Reset and start-up vectors: enable seen in IDLE gives vsync and
    // frame_start two samples later; a reset inside VSYNC clears everything.
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0};
    vecs[2] = '{1, 0, 0, 0};
    vecs[3] = '{1, 1, 0, 0};
    vecs[4] = '{1, 1, 1, 1};
    vecs[5] = '{1, 1, 1, 0};
    vecs[6] = '{0, 1, 0, 0};
    vecs[7] = '{1, 0, 0, 0};

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < NPIX; i++) begin
      sentData[i]  = '0;
      sentValid[i] = 1'b0;
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].en, 1'b1, 16'($urandom));
      @(posedge clk);
      #1;
      checkOutput("vec_vsync", cam_vsync, vecs[i].expVsync);
      checkOutput("vec_fstart", frame_start, vecs[i].expFstart);
      checkOutput("vec_href", cam_href, 0);
      checkOutput("vec_data", cam_data, 0);
      checkOutput("vec_fdone", frame_done, 0);
      checkOutput("vec_uflow", underflow, 0);
      checkOutput("vec_ready", pix_ready, 0);
    end

    $display("[TB] nominal, underflow, starved and random frames back to back");
    pixCounter = 16'hA1B2;
    startFrame();
    runFrame(0, FRAME - 2, 1'b1, -1);
    runFrame(1, FRAME - 2, 1'b1, -1);
    runFrame(2, FRAME - 2, 1'b1, -1);
    runFrame(3, FRAME - 2, 1'b1, -1);
    runFrame(0, FRAME - 2, 1'b1, -1);

    $display("[TB] enable dropped during line 1");
    runFrame(3, L0 + LINE_LEN + 2, 1'b0, -1);
    idleCheck(12);

    $display("[TB] reset during phase 1 of pixel 2");
    startFrame();
    runFrame(0, FRAME - 2, 1'b1, L0 + 4);
    startFrame();
    runFrame(0, FRAME - 2, 1'b0, -1);
    idleCheck(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
